// File: rtl/seq_pow_fact_unit.sv
// Iterative a^n / n! engine: one multiply per cycle against a decrementing counter,
// with a start/busy/done handshake and sticky overflow (optionally saturating).
module seq_pow_fact_unit #(
    parameter int W   = 16,
    parameter int NW  = 5,
    parameter bit SAT = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [W-1:0]  a_in,
    input  logic [NW-1:0] n_in,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic          mode_q, mode_d;
    logic [W-1:0]  result_q, result_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, done_q;

    logic [W-1:0]   mult;
    logic [2*W-1:0] prod;

    function automatic logic [W-1:0] sat_value();
        return '1;
    endfunction

    always_comb begin
        mult = a_q;
        if (mode_q) begin
            mult = '0;
            mult[NW-1:0] = cnt_q;
        end
        prod = {{W{1'b0}}, acc_q} * {{W{1'b0}}, mult};
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        mode_d   = mode_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    cnt_d   = n_in;
                    mode_d  = mode;
                    acc_d   = W'(1);
                    ovf_d   = 1'b0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    result_d = acc_q;
                    state_d  = S_DONE;
                end else begin
                    acc_d = prod[W-1:0];
                    cnt_d = cnt_q - 1'b1;
                    // High half non-zero means the true product no longer fits in W bits
                    if (|prod[2*W-1:W]) begin
                        ovf_d = 1'b1;
                        if (SAT) begin
                            result_d = sat_value();
                            state_d  = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
        end
    end

    // Operand captures only matter once an operation has been accepted
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        mode_q <= mode_d;
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_seq_pow_fact_unit.sv
// Bench for seq_pow_fact_unit: three instances (16-bit, 8-bit wrapping, 8-bit saturating)
// checked against an arithmetic reference model.
module tb_seq_pow_fact_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_v = 3'b000;
    logic        mode = 1'b0;
    logic [15:0] a_in = '0;
    logic [4:0]  n_in = '0;
    logic [2:0]  busy_v, done_v, ovf_v;
    logic [15:0] res16;
    logic [7:0]  res8, res8s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_pow_fact_unit #(.W(16), .NW(5), .SAT(1'b0)) u_w16 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode), .a_in(a_in), .n_in(n_in),
        .busy(busy_v[0]), .done(done_v[0]), .result(res16), .ovf(ovf_v[0]));
    seq_pow_fact_unit #(.W(8), .NW(5), .SAT(1'b0)) u_w8 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode), .a_in(a_in[7:0]), .n_in(n_in),
        .busy(busy_v[1]), .done(done_v[1]), .result(res8), .ovf(ovf_v[1]));
    seq_pow_fact_unit #(.W(8), .NW(5), .SAT(1'b1)) u_w8s (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode), .a_in(a_in[7:0]), .n_in(n_in),
        .busy(busy_v[2]), .done(done_v[2]), .result(res8s), .ovf(ovf_v[2]));

    function automatic int width_of(input int s);
        return (s == 0) ? 16 : 8;
    endfunction

    function automatic logic [15:0] get_res(input int s);
        case (s)
            0:       return res16;
            1:       return {8'h00, res8};
            default: return {8'h00, res8s};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: a^n or n! as plain integer arithmetic, truncated to w bits after each step.
    task automatic model(input int w, input bit sat, input bit md, input longint a, input int n,
                         output longint res, output bit ov, output int lat);
        longint mask, acc, p, m;
        mask = (longint'(1) << w) - 1;
        acc  = 1;
        ov   = 1'b0;
        lat  = n + 1;
        res  = 0;
        for (int i = 1; i <= n; i++) begin
            m = md ? longint'(n - i + 1) : (a & mask);
            p = acc * m;
            if ((p >> w) != 0) begin
                ov = 1'b1;
                if (sat) begin
                    res = mask;
                    lat = i;
                    return;
                end
            end
            acc = p & mask;
        end
        res = acc;
    endtask

    task automatic scramble();
        mode = 1'($urandom);
        a_in = 16'($urandom);
        n_in = 5'($urandom);
    endtask

    task automatic run_op(input int s, input bit md, input logic [15:0] a, input int n);
        longint exp_res;
        bit     exp_ov;
        int     exp_lat;
        int     c;
        bit     busy_err;
        logic [15:0] held;
        model(width_of(s), s == 2, md, longint'(a), n, exp_res, exp_ov, exp_lat);
        @(negedge clk);
        mode = md; a_in = a; n_in = 5'(n); start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        check($sformatf("ovf_clr_s%0d", s), ovf_v[s], 0);
        c = 0;
        busy_err = 1'b0;
        while (!done_v[s] && c < 200) begin
            if (!busy_v[s]) busy_err = 1'b1;
            scramble();
            @(negedge clk);
            c++;
        end
        check($sformatf("busy_s%0d", s), busy_err, 0);
        check($sformatf("lat_s%0d_m%0d_n%0d", s, md, n), c, exp_lat);
        check($sformatf("res_s%0d_m%0d_a%0h_n%0d", s, md, a, n), get_res(s), exp_res);
        check($sformatf("ovf_s%0d_m%0d_a%0h_n%0d", s, md, a, n), ovf_v[s], exp_ov);
        check($sformatf("busy_done_s%0d", s), busy_v[s], 1);
        held = get_res(s);
        @(negedge clk);
        check($sformatf("done_pulse_s%0d", s), done_v[s], 0);
        check($sformatf("idle_s%0d", s), busy_v[s], 0);
        check($sformatf("held_s%0d", s), get_res(s), held);
    endtask

    task automatic check_reset(input string tag);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("%s_busy%0d", tag, s), busy_v[s], 0);
            check($sformatf("%s_done%0d", tag, s), done_v[s], 0);
            check($sformatf("%s_res%0d", tag, s), get_res(s), 0);
            check($sformatf("%s_ovf%0d", tag, s), ovf_v[s], 0);
        end
    endtask

    initial begin
        int pulses, last, cyc;
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;

        // Directed cases
        run_op(0, 1'b0, 16'd3, 4);
        run_op(0, 1'b1, 16'd0, 5);
        run_op(0, 1'b0, 16'd7, 0);
        run_op(0, 1'b1, 16'd7, 0);
        run_op(0, 1'b0, 16'd0, 3);
        run_op(1, 1'b0, 16'd2, 9);
        run_op(1, 1'b0, 16'd2, 3);
        run_op(2, 1'b0, 16'd2, 9);
        run_op(2, 1'b1, 16'd0, 6);
        run_op(2, 1'b0, 16'd2, 3);

        // Start held high: each op re-samples start in IDLE, so pulses are n+3 apart
        @(negedge clk);
        mode = 1'b0; a_in = 16'd2; n_in = 5'd2; start_v[0] = 1'b1;
        pulses = 0; last = 0; cyc = 0;
        while (pulses < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done_v[0]) begin
                check("hold_res", res16, 16'd4);
                check("hold_ovf", ovf_v[0], 0);
                if (pulses > 0) check("hold_gap", cyc - last, 5);
                last = cyc;
                pulses++;
            end
            if (busy_v[0] && !done_v[0]) begin
                a_in = 16'($urandom); n_in = 5'($urandom);
            end else begin
                a_in = 16'd2; n_in = 5'd2;
            end
        end
        check("hold_pulses", pulses, 3);
        start_v[0] = 1'b0;
        repeat (10) @(negedge clk);

        // Reset in the middle of a long power operation
        mode = 1'b0; a_in = 16'd3; n_in = 5'd10; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", busy_v[0], 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_mid");
        rst = 1'b0;
        run_op(0, 1'b0, 16'd3, 10);

        // Randomised operations across all three configurations
        for (int r = 0; r < 40; r++) begin
            int s;
            logic [15:0] a;
            s = int'($urandom_range(0, 2));
            a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
            run_op(s, 1'($urandom), a, int'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
